uart_transmitter: RTL

- Serialises bytes into 10-bit UART frames (start 0, 8 data, stop 1) on uart_tx, one bit per baud tick.
- Sits directly upstream of uart_receiver and shares the baud_rate_generator output with it.
- Accepts bytes through a valid/ready handshake into a small FIFO, so frames can run back-to-back with no idle gap.

---
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: queues bytes through a valid/ready handshake into a small
// FIFO and serialises each one as a 10-bit UART frame (start 0, 8 data, stop 1).
// The line advances only on rising edges of the shared baud tick, so frames
// can follow each other with no idle gap while the FIFO holds data.
module uart_transmitter #(
  parameter int DEPTH     = 4,     // FIFO entries, power of two, >= 2
  parameter bit LSB_FIRST = 1'b1   // 1: tx_data[1] first, 0: tx_data[8] first
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_rate_signal,
  input  logic [8:1] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          baud_q;
  logic          tick;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          empty;
  logic [7:0]    shift;
  logic [7:0]    shift_adv;
  logic          line_bit;
  logic [3:0]    bitcnt;

  // Only the rising edge of the baud signal counts; a level held high is inert.
  assign tick  = baud_rate_signal & ~baud_q;
  assign empty = (count == '0);

  // tx_ready is registered, so a full FIFO refuses a push even on a pop cycle.
  assign push = tx_valid & tx_ready;

  // A byte leaves the FIFO exactly on the tick that loads it into the shifter.
  assign pop = tick & ~empty & ((state == IDLE) | (state == STOP));

  assign count_next = count + CW'(push) - CW'(pop);

  // Bit-order selection: take the bit at the outgoing end and shift toward it.
  assign line_bit  = LSB_FIRST ? shift[0] : shift[7];
  assign shift_adv = LSB_FIRST ? {1'b0, shift[7:1]} : {shift[6:0], 1'b0};

  // Register the baud input so its rising edge can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_rate_signal;
    end
  end

  // FIFO storage; no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      tx_ready <= (count_next != CW'(DEPTH));
    end
  end

  // Frame sequencer with registered line, busy and frame-done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      bitcnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!empty) begin
              shift   <= mem[rd_ptr];
              uart_tx <= 1'b0;
              tx_busy <= 1'b1;
              state   <= START;
            end else begin
              uart_tx <= 1'b1;
            end
          end
          START: begin
            uart_tx <= line_bit;
            shift   <= shift_adv;
            bitcnt  <= 4'd1;
            state   <= DATA;
          end
          DATA: begin
            if (bitcnt < 4'd8) begin
              uart_tx <= line_bit;
              shift   <= shift_adv;
              bitcnt  <= bitcnt + 4'd1;
            end else begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end
          end
          STOP: begin
            frame_done <= 1'b1;
            if (!empty) begin
              // Back-to-back: the next start bit replaces the idle level.
              shift   <= mem[rd_ptr];
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              uart_tx <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
